// File: rtl/alu_defs.sv
// Shared opcode constants, FSM state encoding and opcode helpers for seq_slice_alu.
// SEQ_ALU_SLT_EN makes opcode 0111 (SLT) perform a subtraction.
package alu_defs;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    // Subtracting ops invert B and force the initial carry to 1.
    function automatic logic op_subtracts(input logic [3:0] op);
`ifdef SEQ_ALU_SLT_EN
        return (op == ALU_SUB) || (op == ALU_SLT);
`else
        return (op == ALU_SUB);
`endif
    endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU unit, reused by seq_slice_alu on every RUN cycle.
// SEQ_ALU_SLT_EN enables the SLT subtraction path.
module alu_slice
    import alu_defs::*;
#(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             carry_in,
    input  logic [3:0]       op,
    output logic [SLICE-1:0] result,
    output logic             carry_out,
    output logic             carry_msb
);

    logic [SLICE-1:0] b_eff;
    logic [SLICE:0]   sum_ext;

    // Carry into the MSB is recovered from the sum bit, avoiding an explicit ripple loop.
    always_comb begin
        b_eff     = op_subtracts(op) ? ~b : b;
        sum_ext   = {1'b0, a} + {1'b0, b_eff} + {{SLICE{1'b0}}, carry_in};
        carry_out = sum_ext[SLICE];
        carry_msb = sum_ext[SLICE-1] ^ a[SLICE-1] ^ b_eff[SLICE-1];
        case (op)
            ALU_AND:          result = a & b;
            ALU_OR:           result = a | b;
            ALU_NOR:          result = ~(a | b);
            ALU_ADD, ALU_SUB: result = sum_ext[SLICE-1:0];
`ifdef SEQ_ALU_SLT_EN
            ALU_SLT:          result = sum_ext[SLICE-1:0];
`else
            ALU_SLT:          result = '0;
`endif
            default:          result = '0;
        endcase
    end

endmodule

// File: rtl/seq_slice_alu.sv
// Multi-cycle ALU that evaluates a WIDTH-bit operation SLICE bits per clock, LSB slice first.
// SEQ_ALU_SLT_EN enables the signed set-less-than opcode (0111).
module seq_slice_alu
    import alu_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             CarryIn,
    input  logic [3:0]       ALUOp,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             CarryOut,
    output logic             Zero,
    output logic             Overflow
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    alu_state_t       state;
    alu_state_t       state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] result_final;
    logic [3:0]       op_q;
    logic             carry_q;
    logic             carry_msb_q;
    logic [IDX_W-1:0] idx;
    logic             last_slice;
    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic [SLICE-1:0] slice_res;
    logic             slice_cout;
    logic             slice_cmsb;
    logic             ovf_raw;
    logic             arith;

    assign slice_a    = a_q[int'(idx)*SLICE +: SLICE];
    assign slice_b    = b_q[int'(idx)*SLICE +: SLICE];
    assign last_slice = (idx == IDX_W'(N - 1));
    assign busy       = (state == RUN);

    alu_slice #(.SLICE(SLICE)) u_slice (
        .a         (slice_a),
        .b         (slice_b),
        .carry_in  (carry_q),
        .op        (op_q),
        .result    (slice_res),
        .carry_out (slice_cout),
        .carry_msb (slice_cmsb)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // After the final slice, carry_q holds the MSB carry-out and carry_msb_q the carry into it.
    always_comb begin
        ovf_raw      = carry_msb_q ^ carry_q;
        arith        = (op_q == ALU_ADD) || (op_q == ALU_SUB);
        result_final = shadow;
`ifdef SEQ_ALU_SLT_EN
        if (op_q == ALU_SLT) result_final = {{(WIDTH-1){1'b0}}, shadow[WIDTH-1] ^ ovf_raw};
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            carry_q     <= 1'b0;
            carry_msb_q <= 1'b0;
            idx         <= '0;
            shadow      <= '0;
            Result      <= '0;
            CarryOut    <= 1'b0;
            Zero        <= 1'b0;
            Overflow    <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= ALUOp;
                        carry_q <= op_subtracts(ALUOp) | ((ALUOp == ALU_ADD) & CarryIn);
                        idx     <= '0;
                    end
                end
                RUN: begin
                    shadow[int'(idx)*SLICE +: SLICE] <= slice_res;
                    carry_q     <= slice_cout;
                    carry_msb_q <= slice_cmsb;
                    idx         <= idx + IDX_W'(1);
                end
                DONE: begin
                    Result   <= result_final;
                    CarryOut <= arith & carry_q;
                    Overflow <= arith & ovf_raw;
                    Zero     <= (result_final == '0);
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_slice_alu.sv
// Directed self-checking bench for seq_slice_alu at WIDTH=16, SLICE=4.
// Expectations for opcode 0111 follow SEQ_ALU_SLT_EN.
module tb_seq_slice_alu;

    localparam int WIDTH = 16;
    localparam int SLICE = 4;
    localparam int N     = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             CarryIn;
    logic [3:0]       ALUOp;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Result;
    logic             CarryOut;
    logic             Zero;
    logic             Overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_slice_alu #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .CarryIn  (CarryIn),
        .ALUOp    (ALUOp),
        .busy     (busy),
        .done     (done),
        .Result   (Result),
        .CarryOut (CarryOut),
        .Zero     (Zero),
        .Overflow (Overflow)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Returns at the negedge right after the accepting clock edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [WIDTH-1:0] av,
                                 input logic [WIDTH-1:0] bv, input logic cin);
        @(negedge clk);
        ALUOp   = op;
        a       = av;
        b       = bv;
        CarryIn = cin;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic waitDone(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic runOp(input string tag, input logic [3:0] op, input logic [WIDTH-1:0] av,
                         input logic [WIDTH-1:0] bv, input logic cin, input logic [WIDTH-1:0] er,
                         input logic ec, input logic ez, input logic eo);
        int lat;
        applyStimulus(op, av, bv, cin);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        waitDone(lat);
        checkOutput({tag, "_latency"}, lat, N + 1);
        checkOutput({tag, "_result"}, 32'(Result), 32'(er));
        checkOutput({tag, "_cout"}, 32'(CarryOut), 32'(ec));
        checkOutput({tag, "_zero"}, 32'(Zero), 32'(ez));
        checkOutput({tag, "_ovf"}, 32'(Overflow), 32'(eo));
    endtask

    initial begin
        int pulses;
        int first_k;
        int second_k;
        logic [WIDTH-1:0] r1;
        logic [WIDTH-1:0] r2;

        reset_n = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        CarryIn = 1'b0;
        ALUOp   = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_result", 32'(Result), 32'd0);
        checkOutput("rst_flags", {29'd0, CarryOut, Zero, Overflow}, 32'd0);
        reset_n = 1'b1;

        runOp("add",      4'b0010, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        runOp("add_cin",  4'b0010, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
        runOp("add_ovf",  4'b0010, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1);
        runOp("sub_ovf",  4'b0110, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b1);
        runOp("sub_zero", 4'b0110, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
        runOp("nor",      4'b1100, 16'hF0F0, 16'hFF00, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0);
        runOp("unknown",  4'b1111, 16'hF0F0, 16'hFF00, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
        runOp("or",       4'b0001, 16'hF0F0, 16'hFF00, 1'b0, 16'hFFF0, 1'b0, 1'b0, 1'b0);
        runOp("and",      4'b0000, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        checkOutput("hold_result", 32'(Result), 32'h0000F000);

        // Reset lands on the third RUN cycle of an ADD.
        applyStimulus(4'b0010, 16'h00FF, 16'h0001, 1'b0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_result", 32'(Result), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checkOutput("midrst_no_done", pulses, 0);
        runOp("post_rst", 4'b0010, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);

        // Start held high with operands changed mid-operation.
        @(negedge clk);
        ALUOp   = 4'b0010;
        a       = 16'h0003;
        b       = 16'h0004;
        CarryIn = 1'b0;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a        = 16'hAAAA;
        b        = 16'h5555;
        pulses   = 0;
        first_k  = -1;
        second_k = -1;
        r1       = '0;
        r2       = '0;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                pulses++;
                if (first_k < 0) begin
                    first_k = k;
                    r1      = Result;
                end else begin
                    second_k = k;
                    r2       = Result;
                end
            end
            if (k == 11) start = 1'b0;
        end
        checkOutput("held_pulses", pulses, 2);
        checkOutput("held_first_k", first_k, N + 1);
        checkOutput("held_second_k", second_k, 2 * (N + 2) - 1);
        checkOutput("held_r1", 32'(r1), 32'h00000007);
        checkOutput("held_r2", 32'(r2), 32'h0000FFFF);

`ifdef SEQ_ALU_SLT_EN
        runOp("slt_true",  4'b0111, 16'hFFFF, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0);
        runOp("slt_false", 4'b0111, 16'h0005, 16'hFFFB, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
`else
        runOp("slt_off_a", 4'b0111, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        runOp("slt_off_b", 4'b0111, 16'h0005, 16'hFFFB, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
